// File: rtl/sar_search_ctrl_if.sv
// sar_search_ctrl_if: comparator-side bundle for the SAR search controller
//   master (controller): drives guess/busy/done/result/steps/err, samples start and cmp_eq/gt/lt
//   slave (comparator/host): drives start and flags, observes the controller outputs
interface sar_search_ctrl_if #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 3
);
    logic              start;
    logic              cmp_eq;
    logic              cmp_gt;
    logic              cmp_lt;
    logic [WIDTH-1:0]  guess;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  result;
    logic [STEP_W-1:0] steps;
    logic              err;
    modport master (
        input  start, cmp_eq, cmp_gt, cmp_lt,
        output guess, busy, done, result, steps, err
    );
    modport slave (
        output start, cmp_eq, cmp_gt, cmp_lt,
        input  guess, busy, done, result, steps, err
    );
endinterface

// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: binary-search controller that recovers a hidden value from comparator flags
//   clk, reset (sync, active-high); bus (master): start, cmp_eq/gt/lt in; guess, busy, done, result, steps, err out
//   Optional macro SAR_FLAG_CHECK_EN: a flag vector that is not one-hot forces the error exit
module sar_search_ctrl #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    sar_search_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
    localparam logic [WIDTH-1:0] MAX = '1;
    state_t            r_state;
    logic [WIDTH-1:0]  r_lo, r_hi, r_result;
    logic [STEP_W-1:0] r_cnt, r_steps;
    logic              r_busy, r_done, r_err;
    logic [WIDTH-1:0]  w_guess;
    logic              w_bad, w_gt, w_lt, w_err, w_end;
    // midpoint summed one bit wider so lo+hi never wraps
    assign w_guess = WIDTH'(({1'b0, r_lo} + {1'b0, r_hi}) >> 1);
`ifdef SAR_FLAG_CHECK_EN
    assign w_bad = !({bus.cmp_eq, bus.cmp_gt, bus.cmp_lt} inside {3'b100, 3'b010, 3'b001});
`else
    assign w_bad = 1'b0;
`endif
    // eq > gt > lt; an all-zero vector falls into the lt branch
    assign w_gt  = !bus.cmp_eq && bus.cmp_gt;
    assign w_lt  = !bus.cmp_eq && !bus.cmp_gt;
    assign w_err = w_bad || (w_gt && w_guess == r_lo) || (w_lt && w_guess == r_hi);
    assign w_end = bus.cmp_eq || w_err;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_lo     <= '0;
            r_hi     <= MAX;
            r_cnt    <= '0;
            r_result <= '0;
            r_steps  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_lo    <= '0;
                        r_hi    <= MAX;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= SEARCH;
                    end
                end
                SEARCH: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_end) begin
                        r_result <= w_guess;
                        r_steps  <= r_cnt + 1'b1;
                        r_err    <= w_err;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= DONE;
                    end else if (w_gt) begin
                        r_hi <= w_guess - 1'b1;
                    end else begin
                        r_lo <= w_guess + 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.guess  = w_guess;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.steps  = r_steps;
    assign bus.err    = r_err;
endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Binary-search (successive-approximation) controller that drives a trial operand into an external comparator (guess -> x, hidden target -> y).
- Consumes the comparator's eq/gt/lt flags and converges on the target value.
- Acts as the initiating side of the comparator interface in the ALU test/compute path. Lets a stored or external value be recovered using only comparison results.

Parameters:
- WIDTH, 4, operand width in bits; search range 0 .. 2^WIDTH-1
- STEP_W, 3, width of step counter; must hold WIDTH+1

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a search; sampled only in IDLE
- cmp_eq  input  1  comparator flag: guess == target
- cmp_gt  input  1  comparator flag: guess > target
- cmp_lt  input  1  comparator flag: guess < target
- guess  output  WIDTH  trial operand to comparator; equals (lo+hi)>>1
- busy  output  1  high while in SEARCH
- done  output  1  one-cycle pulse when search ends
- result  output  WIDTH  found value, held until next done
- steps  output  STEP_W  comparisons used in last search, held
- err  output  1  last search ended in error, held until next start

Behaviour:
- Single clock; reset is synchronous and active-high; no other reset.
- Reset values:
  - FSM=IDLE, lo=0, hi=2^WIDTH-1, so guess=(2^WIDTH-1)>>1 (7 for WIDTH=4)
  - busy=0, done=0, result=0, steps=0, err=0
- Internal registers: lo, hi (WIDTH bits each), step counter. Midpoint sum is computed at WIDTH+1 bits, then shifted; no overflow.
- guess is combinational from lo/hi. The comparator is combinational, and flags are sampled on the same edge.
- IDLE:
  - on start=1: lo=0, hi=max, counter=0, err=0; go to SEARCH.
  - start=0: stay in IDLE, outputs held.
- SEARCH: each clock, counter+1 and flags are sampled.
  - cmp_eq: result=guess, steps=counter+1, go to DONE.
  - cmp_gt: if guess==lo, range collapsed -> error exit. Else hi=guess-1.
  - cmp_lt: if guess==hi, range collapsed -> error exit. Else lo=guess+1.
  - Flag priority eq > gt > lt.
  - Error exit: err=1, result=guess, steps=counter+1, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0; next state IDLE unconditionally.
- start while in SEARCH or DONE is ignored; no queuing.
- Latency: start edge -> SEARCH. A search of N comparisons asserts done in the cycle after the Nth sampling edge. The bound is N <= WIDTH+1 for a consistent comparator.
- guess/lo/hi update only in SEARCH. In IDLE/DONE, guess shows the last midpoint.
- Reset mid-search: immediate return to reset values; no done pulse.

Optional Feature:
- Macro SAR_FLAG_CHECK_EN.
- Defined: in SEARCH, any flag vector that is not exactly one-hot is an error. This covers none set or more than one set. The block takes the error exit in that cycle: err=1, result=guess, done pulse next cycle.
- Undefined: no one-hot check. Priority eq > gt > lt applies. All-zero flags are treated as cmp_lt, subject to the range-collapse rule. err is raised only by range collapse.

Test Plan:
- WIDTH=4, target 7 (model comparator), start pulse -> first guess 7, eq. done 2 cycles after start edge; result=7, steps=1, err=0.
- Target 15 -> guesses 7,11,13,14,15 (all lt until eq); result=15, steps=5, done asserted once, busy high 5 cycles.
- Target 0 -> guesses 7,3,1,0; result=0, steps=4, no underflow on hi.
- Inconsistent comparator always reporting gt -> guesses 7,3,1,0; at guess 0 with lo=0, range-collapse error; err=1, result=0, steps=4.
- With SAR_FLAG_CHECK_EN, flags forced 000 on first compare -> err=1, steps=1, result=7. Without the macro, same stimulus proceeds as lt: next guess 11.
- start re-asserted during SEARCH, then reset asserted at 3rd search cycle -> start ignored. The cycle after reset has busy=0, done never pulsed, result/steps/err=0, guess=7.
